// File: rtl/beta_mem_arbiter_if.sv
// Bundles the fetch request, MEM-stage request and external memory bus
// signals shared between the Beta pipeline, the arbiter and the memory.
//   slave  : the arbiter's view (requests and memory responses in)
//   master : the environment's view (pipeline stages plus memory model)
interface beta_mem_arbiter_if;
  // Fetch stage
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  // MEM stage
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  // Pipeline control
  logic        stall;
  // External memory bus
  logic [31:0] bus_addr;
  logic [31:0] bus_wd;
  logic        bus_oe;
  logic        bus_we;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  // Status
  logic        timeout_err;

  modport slave (
    input  if_req, if_addr,
    input  mem_rd, mem_wr, mem_addr, mem_wd,
    input  bus_rdata, bus_ready,
    output if_rdata, if_ack,
    output mem_rdata, mem_ack,
    output stall,
    output bus_addr, bus_wd, bus_oe, bus_we,
    output timeout_err
  );

  modport master (
    output if_req, if_addr,
    output mem_rd, mem_wr, mem_addr, mem_wd,
    output bus_rdata, bus_ready,
    input  if_rdata, if_ack,
    input  mem_rdata, mem_ack,
    input  stall,
    input  bus_addr, bus_wd, bus_oe, bus_we,
    input  timeout_err
  );
endinterface

// File: rtl/beta_mem_arbiter.sv
// Beta memory arbiter: shares one single-ported memory bus between the
// fetch stage and the MEM stage. One transaction at a time, round-robin
// on contention, ready handshake with a bounded wait, and a global
// pipeline stall while any request is still unacknowledged.
module beta_mem_arbiter #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 8
) (
  input logic               clk,
  input logic               rst_n,
  beta_mem_arbiter_if.slave arb_if
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

  state_t             state_q;
  grant_t             last_grant_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [31:0]        bus_addr_q;
  logic [31:0]        bus_wd_q;
  logic               bus_oe_q;
  logic               bus_we_q;
  logic               if_ack_q;
  logic               mem_ack_q;
  logic [31:0]        if_rdata_q;
  logic [31:0]        mem_rdata_q;
  logic               timeout_err_q;

  logic               mem_pend;
  logic               ack_pending;
  logic               grant_mem;
  logic               grant_if;
  logic               wait_expired;

  // Request decode, round-robin grant choice and wait-counter next value
  always_comb begin
    mem_pend     = arb_if.mem_rd | arb_if.mem_wr;
    // No new grant in the cycle an ack is being presented.
    ack_pending  = if_ack_q | mem_ack_q;
    grant_mem    = !ack_pending && mem_pend &&
                   (!arb_if.if_req || (last_grant_q == GRANT_IF));
    grant_if     = !ack_pending && arb_if.if_req &&
                   (!mem_pend || (last_grant_q == GRANT_MEM));
    cnt_d        = cnt_q + 1'b1;
    wait_expired = (cnt_d == CNT_W'(MAX_WAIT));
  end

  // Transaction FSM with registered bus, ack, read-data and error outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= GRANT_IF;
      cnt_q         <= '0;
      bus_addr_q    <= '0;
      bus_wd_q      <= '0;
      bus_oe_q      <= 1'b0;
      bus_we_q      <= 1'b0;
      if_ack_q      <= 1'b0;
      mem_ack_q     <= 1'b0;
      if_rdata_q    <= '0;
      mem_rdata_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_mem) begin
            state_q      <= MEM_BUSY;
            last_grant_q <= GRANT_MEM;
            cnt_q        <= '0;
            bus_addr_q   <= arb_if.mem_addr;
            bus_wd_q     <= arb_if.mem_wd;
            // A store wins when both load and store are requested.
            bus_we_q     <= arb_if.mem_wr;
            bus_oe_q     <= ~arb_if.mem_wr;
          end else if (grant_if) begin
            state_q      <= IF_BUSY;
            last_grant_q <= GRANT_IF;
            cnt_q        <= '0;
            bus_addr_q   <= arb_if.if_addr;
            bus_wd_q     <= '0;
            bus_we_q     <= 1'b0;
            bus_oe_q     <= 1'b1;
          end
        end
        IF_BUSY, MEM_BUSY: begin
          // Completion and abort share one exit path; a late bus_ready on
          // the final wait cycle still counts as a normal completion.
          if (arb_if.bus_ready || wait_expired) begin
            state_q  <= IDLE;
            bus_oe_q <= 1'b0;
            bus_we_q <= 1'b0;
            if (state_q == IF_BUSY) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= arb_if.bus_ready ? arb_if.bus_rdata : '0;
            end else begin
              mem_ack_q   <= 1'b1;
              mem_rdata_q <= (arb_if.bus_ready && !bus_we_q) ? arb_if.bus_rdata : '0;
            end
            if (!arb_if.bus_ready) begin
              timeout_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q  <= IDLE;
          bus_oe_q <= 1'b0;
          bus_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign arb_if.bus_addr    = bus_addr_q;
  assign arb_if.bus_wd      = bus_wd_q;
  assign arb_if.bus_oe      = bus_oe_q;
  assign arb_if.bus_we      = bus_we_q;
  assign arb_if.if_ack      = if_ack_q;
  assign arb_if.mem_ack     = mem_ack_q;
  assign arb_if.if_rdata    = if_rdata_q;
  assign arb_if.mem_rdata   = mem_rdata_q;
  assign arb_if.timeout_err = timeout_err_q;

  // Stall is gated by reset so every output reads 0 while rst_n is low;
  // an acked requester stops stalling in its ack cycle.
  assign arb_if.stall = rst_n &
                        ((mem_pend & ~mem_ack_q) | (arb_if.if_req & ~if_ack_q));

endmodule

// File: tb/tb_beta_mem_arbiter.sv
// Self-checking bench for beta_mem_arbiter: table of single transactions
// against a behavioural memory responder, a scoreboard of expected acks,
// and hand-written contention / round-robin / async-reset sequences.
module tb_beta_mem_arbiter;

  localparam int unsigned MW = 15;

  typedef enum int {K_IF, K_RD, K_WR} kind_e;

  typedef struct {
    kind_e       kind;
    logic [31:0] addr;
    logic [31:0] wd;
    int          lat;     // busy cycles until bus_ready; 0 = never
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    bit          is_mem;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic rst_n;

  beta_mem_arbiter_if bif ();

  beta_mem_arbiter #(
    .MAX_WAIT (MW),
    .CNT_W    (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_if (bif)
  );

  int          n_vec  = 0;
  int          n_bad  = 0;
  int          n_acks = 0;
  int          resp_lat = 1;
  int          busy_cnt = 0;
  bit          exp_to = 1'b0;
  exp_t        sb_q[$];
  logic [31:0] grant_q[$];
  logic [31:0] mem_model [logic [31:0]];
  vec_t        tbl [9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_check(input bit is_mem, input logic [31:0] rd);
    exp_t e;
    n_acks++;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_ack: got %s ack rdata %h expected no ack",
               is_mem ? "mem" : "if", rd);
    end else begin
      e = sb_q.pop_front();
      chk("ack_source", 32'(is_mem), 32'(e.is_mem));
      chk("ack_rdata", rd, e.rdata);
    end
  endtask

  // Memory model: answers after resp_lat busy cycles, logs each grant address
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt      = 0;
      bif.bus_ready = 1'b0;
      bif.bus_rdata = '0;
    end else if (bif.bus_oe || bif.bus_we) begin
      busy_cnt++;
      if (busy_cnt == 1) grant_q.push_back(bif.bus_addr);
      if (resp_lat != 0 && busy_cnt >= resp_lat) begin
        bif.bus_ready = 1'b1;
        if (bif.bus_we) begin
          mem_model[bif.bus_addr] = bif.bus_wd;
          bif.bus_rdata = 32'hA5A5_A5A5;
        end else begin
          bif.bus_rdata = mem_model.exists(bif.bus_addr) ? mem_model[bif.bus_addr] : '0;
        end
      end else begin
        bif.bus_ready = 1'b0;
        bif.bus_rdata = 32'h5A5A_5A5A;
      end
    end else begin
      busy_cnt      = 0;
      bif.bus_ready = 1'b0;
      bif.bus_rdata = 32'h5A5A_5A5A;
    end
  end

  // Ack monitor: every ack must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (bif.mem_ack) sb_check(1'b1, bif.mem_rdata);
      if (bif.if_ack)  sb_check(1'b0, bif.if_rdata);
    end
  end

  task automatic do_txn(input vec_t v);
    int  cyc;
    int  cyc_exp;
    bit  got;
    exp_t e;
    cyc_exp = ((v.lat == 0) ? int'(MW) : v.lat) + 1;
    @(negedge clk);
    resp_lat = v.lat;
    case (v.kind)
      K_IF: begin bif.if_req = 1'b1; bif.if_addr = v.addr; end
      K_RD: begin bif.mem_rd = 1'b1; bif.mem_addr = v.addr; end
      default: begin bif.mem_wr = 1'b1; bif.mem_addr = v.addr; bif.mem_wd = v.wd; end
    endcase
    e.is_mem = (v.kind != K_IF);
    e.rdata  = v.exp_rd;
    sb_q.push_back(e);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < cyc_exp + 5) begin
      @(negedge clk);
      cyc++;
      got = (v.kind == K_IF) ? bif.if_ack : bif.mem_ack;
      if (!got && cyc < cyc_exp) begin
        chk("busy_addr", bif.bus_addr, v.addr);
        chk("busy_we", 32'(bif.bus_we), 32'(v.kind == K_WR));
        chk("busy_oe", 32'(bif.bus_oe), 32'(v.kind != K_WR));
        if (v.kind == K_WR) chk("busy_wd", bif.bus_wd, v.wd);
        chk("busy_stall", 32'(bif.stall), 32'd1);
      end
    end
    chk("ack_latency", cyc, cyc_exp);
    if (got) chk("ack_stall", 32'(bif.stall), 32'd0);
    bif.if_req = 1'b0;
    bif.mem_rd = 1'b0;
    bif.mem_wr = 1'b0;
    if (v.lat == 0) exp_to = 1'b1;
    @(negedge clk);
    chk("post_ack_pulse", 32'({bif.if_ack, bif.mem_ack}), 32'd0);
    chk("post_bus_idle", 32'({bif.bus_oe, bif.bus_we}), 32'd0);
    chk("timeout_err", 32'(bif.timeout_err), 32'(exp_to));
  endtask

  task automatic contention();
    exp_t e;
    bit   got_if;
    grant_q.delete();
    @(negedge clk);
    resp_lat     = 1;
    bif.if_req   = 1'b1;
    bif.if_addr  = 32'h104;
    bif.mem_rd   = 1'b1;
    bif.mem_addr = 32'h200;
    e.is_mem = 1'b1; e.rdata = 32'h2222_0000; sb_q.push_back(e);
    e.is_mem = 1'b0; e.rdata = 32'h0BAD_C0DE; sb_q.push_back(e);
    got_if = 1'b0;
    for (int c = 0; c < 20 && !got_if; c++) begin
      @(negedge clk);
      if (c == 0) chk("cont_stall_start", 32'(bif.stall), 32'd1);
      if (bif.mem_ack) begin
        chk("cont_stall_mid", 32'(bif.stall), 32'd1);
        bif.mem_rd = 1'b0;
      end
      if (bif.if_ack) begin
        chk("cont_stall_end", 32'(bif.stall), 32'd0);
        bif.if_req = 1'b0;
        got_if = 1'b1;
      end
    end
    chk("cont_if_acked", 32'(got_if), 32'd1);
    chk("cont_grants", grant_q.size(), 2);
    if (grant_q.size() >= 2) begin
      chk("cont_first_grant", grant_q[0], 32'h200);
      chk("cont_second_grant", grant_q[1], 32'h104);
    end
    @(negedge clk);
  endtask

  task automatic round_robin();
    exp_t e;
    int   base;
    int   c;
    grant_q.delete();
    base = n_acks;
    for (int i = 0; i < 6; i++) begin
      e.is_mem = (i % 2 == 0);
      e.rdata  = e.is_mem ? 32'h1234_5678 : 32'hDEAD_BEEF;
      sb_q.push_back(e);
    end
    @(negedge clk);
    resp_lat     = 1;
    bif.if_req   = 1'b1;
    bif.if_addr  = 32'h100;
    bif.mem_rd   = 1'b1;
    bif.mem_addr = 32'h40;
    c = 0;
    while (n_acks < base + 6 && c < 60) begin
      @(negedge clk);
      c++;
    end
    bif.if_req = 1'b0;
    bif.mem_rd = 1'b0;
    chk("rr_ack_count", n_acks - base, 6);
    chk("rr_grant_count", grant_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < grant_q.size())
        chk("rr_grant_order", grant_q[i], (i % 2 == 0) ? 32'h40 : 32'h100);
    end
    repeat (3) @(negedge clk);
    chk("rr_timeout_sticky", 32'(bif.timeout_err), 32'd1);
  endtask

  task automatic reset_mid_op();
    @(negedge clk);
    resp_lat    = 0;
    bif.if_req  = 1'b1;
    bif.if_addr = 32'h104;
    repeat (3) @(negedge clk);
    chk("rst_pre_busy", 32'(bif.bus_oe), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_oe", 32'(bif.bus_oe), 32'd0);
    chk("rst_async_addr", bif.bus_addr, 32'd0);
    chk("rst_async_stall", 32'(bif.stall), 32'd0);
    chk("rst_async_timeout", 32'(bif.timeout_err), 32'd0);
    chk("rst_async_if_rdata", bif.if_rdata, 32'd0);
    chk("rst_async_mem_rdata", bif.mem_rdata, 32'd0);
    bif.if_req = 1'b0;
    exp_to = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_stale_ack", 32'({bif.if_ack, bif.mem_ack}), 32'd0);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bif.if_req    = 1'b1;
    bif.if_addr   = 32'h0;
    bif.mem_rd    = 1'b0;
    bif.mem_wr    = 1'b1;
    bif.mem_addr  = 32'h0;
    bif.mem_wd    = 32'h0;
    bif.bus_rdata = 32'h0;
    bif.bus_ready = 1'b0;
    mem_model[32'h100] = 32'hDEAD_BEEF;
    mem_model[32'h104] = 32'h0BAD_C0DE;
    mem_model[32'h200] = 32'h2222_0000;

    tbl[0] = '{K_IF, 32'h100, 32'h0,         1, 32'hDEAD_BEEF};
    tbl[1] = '{K_WR, 32'h040, 32'h1234_5678, 4, 32'h0};
    tbl[2] = '{K_RD, 32'h040, 32'h0,         1, 32'h1234_5678};
    tbl[3] = '{K_WR, 32'h044, 32'hCAFE_F00D, 2, 32'h0};
    tbl[4] = '{K_RD, 32'h044, 32'h0,         3, 32'hCAFE_F00D};
    tbl[5] = '{K_IF, 32'h104, 32'h0,         2, 32'h0BAD_C0DE};
    tbl[6] = '{K_RD, 32'h300, 32'h0,         0, 32'h0};
    tbl[7] = '{K_RD, 32'h040, 32'h0,         1, 32'h1234_5678};
    tbl[8] = '{K_IF, 32'h100, 32'h0,         1, 32'hDEAD_BEEF};

    repeat (2) @(negedge clk);
    chk("reset_bus_addr", bif.bus_addr, 32'd0);
    chk("reset_bus_wd", bif.bus_wd, 32'd0);
    chk("reset_bus_ctl", 32'({bif.bus_oe, bif.bus_we}), 32'd0);
    chk("reset_acks", 32'({bif.if_ack, bif.mem_ack}), 32'd0);
    chk("reset_if_rdata", bif.if_rdata, 32'd0);
    chk("reset_mem_rdata", bif.mem_rdata, 32'd0);
    chk("reset_timeout", 32'(bif.timeout_err), 32'd0);
    chk("reset_stall", 32'(bif.stall), 32'd0);
    bif.if_req = 1'b0;
    bif.mem_wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    contention();
    for (int i = 0; i < 9; i++) do_txn(tbl[i]);
    round_robin();
    reset_mid_op();
    contention();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
